// File: rtl/cnt_seq_ctrl.sv
// Period timer controller: sequences a reloadable down-counter for a configured
// number of periods with start/pause/abort, producing tc, a divided f_out and done.
module cnt_seq_ctrl #(
  parameter int          WIDTH    = 4,
  parameter int unsigned DEF_LOAD = 10,
  parameter int          RPT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [RPT_W-1:0] cfg_rpt,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             f_out,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] load_reg, load_n;
  logic [RPT_W-1:0] rpt_reg, rpt_n;
  logic [RPT_W-1:0] left, left_n;
  logic [WIDTH-1:0] cnt_n;
  logic             f_n, tc_n, done_n;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_reg <= WIDTH'(DEF_LOAD);
      rpt_reg  <= RPT_W'(1);
      cnt      <= WIDTH'(DEF_LOAD);
      left     <= '0;
      f_out    <= 1'b0;
      tc       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      load_reg <= load_n;
      rpt_reg  <= rpt_n;
      cnt      <= cnt_n;
      left     <= left_n;
      f_out    <= f_n;
      tc       <= tc_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    load_n  = load_reg;
    rpt_n   = rpt_reg;
    cnt_n   = cnt;
    left_n  = left;
    f_n     = f_out;
    tc_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_we) begin
          if (cfg_load != '0) load_n = cfg_load;
          rpt_n = cfg_rpt;
        end
        // load_n/rpt_n already carry a same-cycle config write (bypass into the run)
        cnt_n = load_n;
        if (start) begin
          state_n = RUN;
          f_n     = 1'b0;
          left_n  = rpt_n;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = load_reg;
          left_n  = '0;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (cnt > WIDTH'(1)) begin
          cnt_n = cnt - WIDTH'(1);
        end else begin
          cnt_n = load_reg;
          tc_n  = 1'b1;
          f_n   = ~f_out;
          if (rpt_reg != '0) begin
            if (left == RPT_W'(1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
              left_n  = '0;
            end else begin
              left_n = left - RPT_W'(1);
            end
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = load_reg;
          left_n  = '0;
        end else if (!pause) begin
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed scenarios followed by random stimulus, all
// checked every cycle against a period/elapsed-edge reference model.
module tb_cnt_seq_ctrl;

  localparam int W  = 4;
  localparam int RW = 4;
  localparam int DEF = 10;

  logic          clk = 1'b0;
  logic          rst, cfg_we, start, pause, abort;
  logic [W-1:0]  cfg_load;
  logic [RW-1:0] cfg_rpt;
  logic          busy, tc, f_out, done;
  logic [W-1:0]  cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cnt_seq_ctrl #(.WIDTH(W), .DEF_LOAD(DEF), .RPT_W(RW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_load(cfg_load), .cfg_rpt(cfg_rpt),
    .start(start), .pause(pause), .abort(abort), .busy(busy), .cnt(cnt),
    .tc(tc), .f_out(f_out), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a sequence of periods, each L edges long; m_pos
  // counts edges elapsed in the current period, m_left counts periods to go.
  bit m_run, m_pause, m_f, m_tc, m_done;
  int m_L, m_R, m_pos, m_left;

  task automatic model_edge(input bit r, input bit we, input int ld, input int rp,
                            input bit st, input bit pa, input bit ab);
    m_tc = 0;
    m_done = 0;
    if (r) begin
      m_run = 0; m_pause = 0; m_f = 0; m_L = DEF; m_R = 1; m_pos = 0; m_left = 0;
    end else if (!m_run) begin
      if (we) begin
        if (ld != 0) m_L = ld;
        m_R = rp;
      end
      if (st) begin
        m_run = 1; m_pause = 0; m_f = 0; m_pos = 0; m_left = m_R;
      end
    end else if (ab) begin
      m_run = 0; m_pause = 0; m_pos = 0;
    end else if (m_pause) begin
      if (!pa) m_pause = 0;
    end else if (pa) begin
      m_pause = 1;
    end else begin
      m_pos++;
      if (m_pos == m_L) begin
        m_pos = 0;
        m_tc = 1;
        m_f = !m_f;
        if (m_R != 0) begin
          m_left--;
          if (m_left == 0) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit we, input int ld, input int rp,
                      input bit st, input bit pa, input bit ab);
    int exp_cnt;
    rst = r; cfg_we = we; cfg_load = W'(ld); cfg_rpt = RW'(rp);
    start = st; pause = pa; abort = ab;
    @(posedge clk);
    cyc++;
    model_edge(r, we, ld, rp, st, pa, ab);
    #1;
    exp_cnt = m_run ? (m_L - m_pos) : m_L;
    chk("cnt", 32'(cnt), 32'(exp_cnt));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("f_out", 32'(f_out), 32'(m_f));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_run));
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Steps idle until tc is seen; returns edges taken, or -1 on timeout.
  task automatic wait_tc(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      idle_step();
      if (tc) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int val, input int max);
    bit hit = 0;
    for (int i = 0; i < max; i++) begin
      if (32'(cnt) == val) begin
        hit = 1;
        break;
      end
      idle_step();
    end
    chk("wait_cnt_reached", 32'(hit), 32'd1);
  endtask

  int n, start_cyc, tcs, dones;

  initial begin
    m_run = 0; m_pause = 0; m_f = 0; m_tc = 0; m_done = 0;
    m_L = DEF; m_R = 1; m_pos = 0; m_left = 0;

    // Reset and default two-period run
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", 32'(cnt), 32'd10);
    chk("rst_busy", 32'(busy), 32'd0);
    step(0, 1, 10, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    start_cyc = cyc;
    wait_tc(30, n);
    chk("first_tc_edge", 32'(n), 32'd10);
    chk("f_out_after_tc1", 32'(f_out), 32'd1);
    wait_tc(30, n);
    chk("second_tc_edge", 32'(cyc - start_cyc), 32'd20);
    chk("done_with_tc2", 32'(done), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("f_out_after_tc2", 32'(f_out), 32'd0);
    chk("cnt_back_to_load", 32'(cnt), 32'd10);

    // Config bypass: write and start in the same cycle
    step(0, 1, 3, 1, 1, 0, 0);
    chk("bypass_cnt0", 32'(cnt), 32'd3);
    idle_step();
    idle_step();
    chk("bypass_cnt2", 32'(cnt), 32'd1);
    idle_step();
    chk("bypass_tc", 32'(tc), 32'd1);
    chk("bypass_done", 32'(done), 32'd1);

    // Pause stretches the period by pause cycles + 1
    step(0, 1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    start_cyc = cyc;
    idle_step();
    idle_step();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("pause_hold_cnt", 32'(cnt), 32'd3);
    wait_tc(20, n);
    chk("pause_tc_edge", 32'(cyc - start_cyc), 32'd10);
    chk("pause_done", 32'(done), 32'd1);

    // Abort with ignored start/cfg_we mid-run
    step(0, 1, 10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    start_cyc = cyc;
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0);
    wait_tc(30, n);
    chk("abort_period", 32'(cyc - start_cyc), 32'd10);
    wait_cnt(4, 20);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_cnt", 32'(cnt), 32'd10);
    chk("abort_f_hold", 32'(f_out), 32'd1);

    // Reset mid-run, then illegal zero load is ignored
    step(0, 0, 0, 0, 1, 0, 0);
    wait_cnt(6, 20);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    wait_tc(30, n);
    chk("zero_load_ignored", 32'(n), 32'd10);

    // load=1: tc every edge
    step(0, 1, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    tcs = 0;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      tcs += int'(tc);
    end
    chk("load1_tcs", 32'(tcs), 32'd3);
    chk("load1_done", 32'(done), 32'd1);
    chk("load1_f", 32'(f_out), 32'd1);

    // rpt=0 with load=2 runs forever
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    tcs = 0;
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      idle_step();
      tcs += int'(tc);
      dones += int'(done);
    end
    chk("forever_tcs", 32'(tcs), 32'd12);
    chk("forever_no_done", 32'(dones), 32'd0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
Controller that sequences a reloadable down-counter (default 10→1) as a programmable period timer.
- Holds configuration: reload value and repeat count.
- Runs the counter for a configured number of periods, with start, pause and abort control.
- Toggles a divided output each period and raises a terminal-count pulse each period, plus a completion pulse after the last one.
- Sits between the lab-board control logic (buttons/switches) and the counter/divider outputs that drive LEDs and 7-seg.

Parameters:
- WIDTH, 4, counter and reload-value width.
- DEF_LOAD, 10, reload value after reset.
- RPT_W, 4, repeat-count width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_load  in  WIDTH  new reload value; 0 is illegal and ignored (keeps old value).
- cfg_rpt  in  RPT_W  number of periods per run; 0 = run forever.
- start  in  1  begin a run; honoured only in IDLE.
- pause  in  1  level; holds the counter while high.
- abort  in  1  terminates a run immediately.
- busy  out  1  high in RUN or PAUSE.
- cnt  out  WIDTH  current counter value.
- tc  out  1  one-cycle terminal-count pulse, once per period.
- f_out  out  1  divided output; toggles once per period.
- done  out  1  one-cycle pulse at the end of a finite run.

Behaviour:
- Reset (synchronous, active-high):
  - rst=1 at an edge: state=IDLE, load_reg=DEF_LOAD, rpt_reg=1, cnt=DEF_LOAD, left=0, f_out=0, tc=0, done=0, busy=0.
  - rst has priority over every other input.
  - rst mid-run aborts silently: no done pulse.
- Registered outputs: tc and done default to 0 every cycle unless set below. All outputs are registered.
- States: IDLE, RUN, PAUSE. busy = (state != IDLE).
- IDLE:
  - cfg_we=1: load_reg<=cfg_load if nonzero; rpt_reg<=cfg_rpt.
  - start=1: state<=RUN, f_out<=0, cnt<=load value, left<=rpt value.
  - cfg_we and start in the same cycle: the run uses the new cfg values (bypass), and they are also stored.
  - cnt rests at load_reg.
- RUN, priority abort > pause > count:
  - abort: state<=IDLE, cnt<=load_reg, f_out holds, no tc, no done.
  - pause: state<=PAUSE; cnt holds; no decrement this edge.
  - cnt>1: cnt<=cnt-1.
  - cnt==1: cnt<=load_reg, tc<=1, f_out<=~f_out.
    - If rpt_reg!=0 and left==1: state<=IDLE, done<=1 (same cycle as tc), left<=0.
    - Else if rpt_reg!=0: left<=left-1.
- PAUSE:
  - abort: behaves as in RUN.
  - pause=0: state<=RUN; cnt holds this edge; counting resumes on the next edge.
  - cnt, f_out and left all frozen while in PAUSE.
- Period timing:
  - Period = load_reg edges.
  - With start sampled at edge E0, the first tc is visible after edge E0+load_reg.
  - Subsequent tc pulses follow every load_reg edges, each PAUSE stretching the gap by (pause cycles + 1).
- load_reg=1: cnt stays 1, and tc/f_out toggle every RUN edge.
- Ignored inputs:
  - start while busy: ignored.
  - cfg_we while busy: ignored; a run always uses a stable configuration.
- rpt_reg=0: runs until abort or rst; done is never asserted.
- cnt never wraps below 1 and never exceeds load_reg while busy.

Test Plan:
- Default run: rst 2 cycles, cfg_we with cfg_load=10, cfg_rpt=2, then start 1 cycle → tc pulses 10 and 20 edges after the start edge; f_out reads 1 then 0; done high together with the second tc; busy falls on that same edge; cnt returns to 10.
- Config bypass: in IDLE, cfg_we+start together with cfg_load=3, cfg_rpt=1 → cnt 3,2,1; tc+done 3 edges after start; f_out=1.
- Pause: load=5, rpt=1, assert pause for 4 cycles when cnt=3 → cnt holds at 3; tc delayed from edge 5 to edge 10 (4 pause cycles + 1 resume edge); done still issued.
- Abort and ignored inputs: load=10, rpt=0, abort at cnt=4 → IDLE next edge, cnt=10, no tc/done, f_out unchanged; start and cfg_we pulsed mid-run beforehand are ignored (period stays 10).
- Reset mid-run: rst while cnt=6 in RUN → next cycle cnt=10, f_out=0, busy=0, done=0; cfg_load=0 write in IDLE afterwards leaves load_reg=10.
- Edge cases: load=1, rpt=3 → tc on 3 consecutive edges, f_out 1,0,1, done on the third; rpt=0 with load=2 → tc every 2 edges for 20+ cycles, never done.
